// File: rtl/ipg_tx_sched_pkg.sv
// Shared types and constants for the IPG transmit scheduler.
// Optional build macro IPG_SCHED_RESP_PRIO_EN is consumed by ipg_rr_arb.
package ipg_pkg;

    localparam int DATA_WIDTH     = 64;
    localparam int HDR_WIDTH      = 8;
    localparam int MSG_WIDTH      = HDR_WIDTH + 512;
    localparam int MSG_BYTES      = MSG_WIDTH / 8;
    localparam int TAG_WIDTH      = 8;
    localparam int FRAG_WIDTH     = DATA_WIDTH - TAG_WIDTH;
    localparam int MAX_FRAG_BYTES = 7;

    // Tag bit positions inside tx_ipg_data[7:0]
    localparam int TAG_SOM = 0;
    localparam int TAG_EOM = 1;
    localparam int TAG_SRC = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    typedef enum logic {
        SRC_REQ  = 1'b0,
        SRC_RESP = 1'b1
    } src_t;

    // Whole bytes that fit in the advertised idle gap, clamped to one fragment.
    function automatic logic [2:0] gap_cap(input logic [5:0] gap_bits);
        logic [5:0] whole_bytes;
        whole_bytes = gap_bits >> 3;
        if (whole_bytes > 6'(MAX_FRAG_BYTES)) begin
            return 3'(MAX_FRAG_BYTES);
        end
        return whole_bytes[2:0];
    endfunction

endpackage

// File: rtl/ipg_tx_sched_if.sv
// Message-queue and PCS-side signal bundle of the IPG transmit scheduler.
// master = environment (queues + PCS), slave = scheduler.
interface ipg_tx_sched_if;
    import ipg_pkg::*;

    logic [MSG_WIDTH-1:0]  s_req_msg;
    logic                  s_req_valid;
    logic                  s_req_ready;
    logic [MSG_WIDTH-1:0]  s_resp_msg;
    logic                  s_resp_valid;
    logic                  s_resp_ready;
    logic [5:0]            tx_gap_len;
    logic [DATA_WIDTH-1:0] tx_ipg_data;
    logic                  tx_ipg_valid;
    logic [5:0]            tx_ipg_len;
    logic                  busy;
    logic                  cur_src;

    modport master (
        output s_req_msg, s_req_valid, s_resp_msg, s_resp_valid, tx_gap_len,
        input  s_req_ready, s_resp_ready, tx_ipg_data, tx_ipg_valid, tx_ipg_len,
               busy, cur_src
    );

    modport slave (
        input  s_req_msg, s_req_valid, s_resp_msg, s_resp_valid, tx_gap_len,
        output s_req_ready, s_resp_ready, tx_ipg_data, tx_ipg_valid, tx_ipg_len,
               busy, cur_src
    );

endinterface

// File: rtl/ipg_rr_arb.sv
// Two-input arbiter with one-hot grant.
// Default: round-robin, pointer moves past the winner on each advance.
// With IPG_SCHED_RESP_PRIO_EN defined the response input wins outright.
module ipg_rr_arb
    import ipg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    src_t ptr;

    // Grant selection from the current valids and pointer
    always_comb begin
        // NOTE: assign every always_comb output a default first so no path leaves it unassigned (latch).
        grant = 2'b00;
`ifdef IPG_SCHED_RESP_PRIO_EN
        if (valid[SRC_RESP]) begin
            grant = 2'b10;
        end else if (valid[SRC_REQ]) begin
            grant = 2'b01;
        end
`else
        if (valid == 2'b11) begin
            grant = (ptr == SRC_RESP) ? 2'b10 : 2'b01;
        end else begin
            grant = valid;
        end
`endif
    end

    // Pointer hands priority to the other source after every accepted grant
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            ptr <= SRC_REQ;
        end else if (advance && (grant != 2'b00)) begin
            ptr <= grant[SRC_RESP] ? SRC_REQ : SRC_RESP;
        end
    end

endmodule

// File: rtl/ipg_tx_sched.sv
// IPG transmit scheduler: accepts whole 520-bit messages from the request
// and response queues and emits them MSB-first as byte fragments sized to
// the idle-gap capacity reported by the PCS each cycle.
// Build option: IPG_SCHED_RESP_PRIO_EN (strict response priority).
module ipg_tx_sched
    import ipg_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ipg_tx_sched_if.slave bus
);

    state_t                 state;
    logic [MSG_WIDTH-1:0]   shreg;
    logic [6:0]             remaining;
    logic                   som_pending;
    src_t                   cur_src_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   valid_q;
    logic [5:0]             len_q;
    logic                   busy_q;

    logic [1:0]             grant;
    logic                   idle;
    logic                   accept;
    logic [2:0]             cap;
    logic [2:0]             n_bytes;
    logic                   eom;
    logic [FRAG_WIDTH-1:0]  frag;
    logic [TAG_WIDTH-1:0]   tag;

    ipg_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({bus.s_resp_valid, bus.s_req_valid}),
        .advance (accept),
        .grant   (grant)
    );

    // Ready is only offered while idle and out of reset, to the granted source
    assign idle             = (state == ST_IDLE) && !rst;
    assign accept           = idle && (grant != 2'b00);
    assign bus.s_req_ready  = idle && grant[SRC_REQ];
    assign bus.s_resp_ready = idle && grant[SRC_RESP];

    // Fragment size and contents for the current SEND cycle
    always_comb begin
        cap     = gap_cap(bus.tx_gap_len);
        n_bytes = ({4'b0, cap} < remaining) ? cap : remaining[2:0];
        eom     = (remaining == {4'b0, n_bytes});
        frag    = '0;
        for (int i = 0; i < MAX_FRAG_BYTES; i++) begin
            if (3'(i) < n_bytes) begin
                frag[FRAG_WIDTH-1-8*i -: 8] = shreg[MSG_WIDTH-1-8*i -: 8];
            end
        end
        tag          = '0;
        tag[TAG_SOM] = som_pending;
        tag[TAG_EOM] = eom;
        tag[TAG_SRC] = cur_src_q;
    end

    // Message FSM with registered fragment outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            remaining   <= '0;
            som_pending <= 1'b0;
            cur_src_q   <= SRC_REQ;
            data_q      <= '0;
            valid_q     <= 1'b0;
            len_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    len_q   <= '0;
                    if (accept) begin
                        shreg       <= grant[SRC_RESP] ? bus.s_resp_msg : bus.s_req_msg;
                        cur_src_q   <= grant[SRC_RESP] ? SRC_RESP : SRC_REQ;
                        remaining   <= 7'(MSG_BYTES);
                        som_pending <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (n_bytes == 3'd0) begin
                        // No room in this gap: emit nothing, keep the message as is
                        valid_q <= 1'b0;
                        data_q  <= '0;
                        len_q   <= '0;
                    end else begin
                        valid_q     <= 1'b1;
                        data_q      <= {frag, tag};
                        len_q       <= {n_bytes, 3'b000};
                        shreg       <= shreg << {n_bytes, 3'b000};
                        remaining   <= remaining - {4'b0, n_bytes};
                        som_pending <= 1'b0;
                        if (eom) begin
                            busy_q <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ipg_data  = data_q;
    assign bus.tx_ipg_valid = valid_q;
    assign bus.tx_ipg_len   = len_q;
    assign bus.busy         = busy_q;
    assign bus.cur_src      = cur_src_q;

endmodule

// File: doc/ipg_tx_sched.md
# ipg_tx_sched

Transmit-side scheduler for the IPG side channel. It accepts whole 520-bit IPG messages (8-bit header plus 512-bit payload) from two requesters, the memory-request queue and the memory-response queue, and arbitrates between them. It then slices the granted message into byte fragments sized to the idle-gap capacity that the PCS reports each cycle. It sits between the request/response message queues and the 64-bit IPG insertion point of the TX PCS.

## Interface
Parameters:
- `DATA_WIDTH`, 64: IPG word width; fixed at 64.
- `HDR_WIDTH`, 8: message header width.
- `MSG_WIDTH`, 520: message width (`HDR_WIDTH` + 512); must be a multiple of 8.

Ports:
- `clk`  in  1  single clock for the block.
- `rst`  in  1  synchronous, active-high reset.
- `s_req_msg`  in  520  request message; header in [519:512].
- `s_req_valid`  in  1  request message offered.
- `s_req_ready`  out  1  request message accepted when valid & ready.
- `s_resp_msg`  in  520  response message; same layout.
- `s_resp_valid`  in  1  response message offered.
- `s_resp_ready`  out  1  response message accepted when valid & ready.
- `tx_gap_len`  in  6  idle-gap payload capacity this cycle, in bits.
- `tx_ipg_data`  out  64  fragment word: bytes in [63:8], tag in [7:0].
- `tx_ipg_valid`  out  1  fragment present this cycle.
- `tx_ipg_len`  out  6  payload bits used by the fragment (multiple of 8).
- `busy`  out  1  a message is held or being sent.
- `cur_src`  out  1  source of the held message: 0 = req, 1 = resp.

## Operation
- FSM states: IDLE, SEND.
- **IDLE:**
  - The arbiter grants one source with valid high.
  - The ready of the granted source is high combinationally.
  - On handshake: latch the message into a 520-bit shift register, set remaining = 65 bytes, set `cur_src`, move to SEND.
  - The round-robin pointer moves to the other source after each grant.
- **Capacity:** cap = `tx_gap_len` >> 3 bytes, clamped to 7. Non-multiples of 8 round down.
- **SEND:**
  - When cap = 0: `tx_ipg_valid` = 0 and all state holds.
  - Otherwise, n = min(cap, remaining) bytes are taken MSB-first into `tx_ipg_data[63:64-8n]`. Unused bytes are zero.
  - Outputs: `tx_ipg_len` = 8n. Shift register shifts left by 8n. remaining -= n.
  - Tag bits: bit0 SOM (first fragment), bit1 EOM (remaining becomes 0), bit2 = `cur_src`. Bits [7:3] are 0.
  - On EOM, go to IDLE.
- Both ready outputs are 0 in SEND. Only one message is held at a time.
- Arithmetic: remaining is 7 bits (0..65). n is 3 bits. 8n fits in 6 bits (max 56).

## Timing
- Reset values:
  - `s_req_ready` = 0 and `s_resp_ready` = 0 while `rst` is high.
  - `tx_ipg_data` = 0, `tx_ipg_valid` = 0, `tx_ipg_len` = 0, `busy` = 0, `cur_src` = 0.
  - State = IDLE; round-robin pointer = req.
- Fragment outputs are registered. A message accepted at cycle N gives its SOM fragment no earlier than cycle N+2:
  - N+1 is the first SEND cycle, when `tx_gap_len` is sampled.
  - The fragment is registered and visible at N+2.
- EOM cycle is followed by at least one IDLE cycle. Back-to-back messages leave a one-cycle bubble.
- At full capacity (56 bits every cycle), a message takes 10 fragments: nine of 7 bytes plus one of 2 bytes.
- Simultaneous valids: the grant follows the pointer. Valid on only one source grants it regardless of the pointer.
- Reset mid-message:
  - The held message is dropped and no EOM is emitted.
  - Downstream discards the partial message on the next SOM.
- Valid deasserted before ready: no grant and no effect.

## Configuration
- `IPG_SCHED_RESP_PRIO_EN`:
  - Defined: the response source has strict priority whenever `s_resp_valid` is high. The pointer is unused.
  - Undefined: 2-way round-robin as above.

## Structure
- Package `ipg_pkg` holds:
  - `MSG_WIDTH` and `HDR_WIDTH`.
  - Tag bit indices (SOM = 0, EOM = 1, SRC = 2).
  - Max fragment bytes (7).
  - The FSM state enum and the source enum (REQ = 0, RESP = 1).
- Sub-module `ipg_rr_arb`: a 2-input round-robin arbiter. It takes two valids and an advance strobe, and outputs a one-hot grant. The priority macro applies inside it.

## Test plan
- Single req with header 0xA5 and `tx_gap_len` = 56 every cycle:
  - One `s_req_ready` pulse, then 10 fragments with tag 0x01 first and 0x02 last.
  - First `tx_ipg_data[63:56]` = 0xA5. Last `tx_ipg_len` = 16.
- Same message with `tx_gap_len` alternating 56 and 0:
  - No valid output on zero cycles; the data sequence is identical to the first test.
- Both sources valid continuously with the macro undefined:
  - Grants alternate req, resp, req.
  - Resp fragments carry tag bit2 = 1.
- Same stimulus with `IPG_SCHED_RESP_PRIO_EN` defined:
  - Only resp is granted.
- `tx_gap_len` = 24 every cycle:
  - 22 fragments, 21 of 24 bits and one of 16 bits.
- `tx_gap_len` = 60, then 13:
  - Fragment lengths clamp to 56 and round down to 8.
- `rst` pulse after the 4th fragment:
  - All outputs are 0 on the next cycle and the pointer is back at req.
  - The next message starts with SOM.
